// File: rtl/sync_ram.sv
// Single-port word RAM with a priority debug backdoor and a full-memory zero sweep.
// Reset or clear runs a DEPTH-cycle sweep; accesses complete one cycle after acceptance.
module sync_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 16,
    parameter int DEPTH      = 1 << ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  ack,
    input  logic                  dbg_req,
    input  logic                  dbg_we,
    input  logic [ADDR_WIDTH-1:0] dbg_addr,
    input  logic [DATA_WIDTH-1:0] dbg_wdata,
    output logic [DATA_WIDTH-1:0] dbg_rdata,
    output logic                  dbg_ack,
    output logic                  err,
    input  logic                  clear,
    output logic                  busy
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_A = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [IDX_W-1:0]    LAST    = IDX_W'(DEPTH - 1);

    typedef enum logic {S_CLEAR, S_RUN} state_t;

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      cnt_q, cnt_d;
    logic                  ack_q, dbg_ack_q, err_q;
    logic [DATA_WIDTH-1:0] rdata_q, dbg_rdata_q;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  acc_main, acc_dbg, acc, clr_we;
    logic                  a_we, in_range;
    logic [ADDR_WIDTH-1:0] a_addr;
    logic [DATA_WIDTH-1:0] a_wdata;
    logic [IDX_W-1:0]      a_idx;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_main = 1'b0;
        acc_dbg  = 1'b0;
        clr_we   = 1'b0;
        case (state_q)
            S_CLEAR: begin
                clr_we = 1'b1;
                if (cnt_q == LAST) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                // A clear request wins over any access presented in the same cycle.
                if (clear) begin
                    state_d = S_CLEAR;
                    cnt_d   = '0;
                end else if (dbg_req) begin
                    acc_dbg = 1'b1;
                end else if (req) begin
                    acc_main = 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        acc      = acc_main | acc_dbg;
        a_we     = acc_dbg ? dbg_we    : we;
        a_addr   = acc_dbg ? dbg_addr  : addr;
        a_wdata  = acc_dbg ? dbg_wdata : wdata;
        in_range = {1'b0, a_addr} < DEPTH_A;
        a_idx    = a_addr[IDX_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (clr_we)
            mem[cnt_q] <= '0;
        else if (acc && a_we && in_range)
            mem[a_idx] <= a_wdata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_CLEAR;
            cnt_q       <= '0;
            ack_q       <= 1'b0;
            dbg_ack_q   <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
            dbg_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ack_q     <= acc_main;
            dbg_ack_q <= acc_dbg;
            err_q     <= acc && !in_range;
            if (acc_main && !a_we)
                rdata_q <= in_range ? mem[a_idx] : '0;
            if (acc_dbg && !a_we)
                dbg_rdata_q <= in_range ? mem[a_idx] : '0;
        end
    end

    assign busy      = (state_q == S_CLEAR);
    assign ack       = ack_q;
    assign dbg_ack   = dbg_ack_q;
    assign err       = err_q;
    assign rdata     = rdata_q;
    assign dbg_rdata = dbg_rdata_q;
endmodule

// File: tb/tb_sync_ram.sv
// Randomized scoreboard bench for sync_ram (DEPTH=16, ADDR_WIDTH=8, DATA_WIDTH=8).
// The driver predicts each response from an array model; a negedge monitor pops and compares.
module tb_sync_ram;
    localparam int DW = 8;
    localparam int AW = 8;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          reset, req, we, dbg_req, dbg_we, clear;
    logic [AW-1:0] addr, dbg_addr;
    logic [DW-1:0] wdata, dbg_wdata, rdata, dbg_rdata;
    logic          ack, dbg_ack, err, busy;

    sync_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .req(req), .we(we), .addr(addr), .wdata(wdata), .rdata(rdata), .ack(ack),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack),
        .err(err), .clear(clear), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int      cyc;
        logic [DW-1:0] rd;
        logic    err;
    } exp_t;

    exp_t q_main[$];
    exp_t q_dbg[$];
    logic [DW-1:0] model [DEPTH];
    logic [DW-1:0] last_rd [2];
    int cyc = 0;
    int errors = 0;
    int checks = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Higher-level model: memory array plus last-read value per port.
    function automatic void exp_acc(input bit dbg, input bit w, input int a, input logic [DW-1:0] d);
        exp_t e;
        bit inr = (a < DEPTH);
        if (w && inr) model[a] = d;
        if (!w) last_rd[dbg] = inr ? model[a] : '0;
        e.cyc = cyc + 1;
        e.rd  = last_rd[dbg];
        e.err = !inr;
        if (dbg) q_dbg.push_back(e);
        else     q_main.push_back(e);
    endfunction

    function automatic void model_zero();
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req = 0; we = 0; addr = '0; wdata = '0;
        dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
        clear = 0;
    endtask

    task automatic issue(input bit dbg, input bit w, input int a, input logic [DW-1:0] d);
        idle();
        if (dbg) begin
            dbg_req = 1; dbg_we = w; dbg_addr = AW'(a); dbg_wdata = d;
        end else begin
            req = 1; we = w; addr = AW'(a); wdata = d;
        end
        exp_acc(dbg, w, a, d);
    endtask

    task automatic collide(input bit mw, input int ma, input logic [DW-1:0] md,
                           input bit dw, input int da, input logic [DW-1:0] dd);
        idle();
        req = 1; we = mw; addr = AW'(ma); wdata = md;
        dbg_req = 1; dbg_we = dw; dbg_addr = AW'(da); dbg_wdata = dd;
        exp_acc(1, dw, da, dd);
        step();
        dbg_req = 0;
        exp_acc(0, mw, ma, md);
        step();
    endtask

    // Counts busy cycles from the current one; optionally pokes clear mid-sweep.
    task automatic count_busy(input int clr_at, input int exp_n);
        int n = 0;
        while (busy === 1'b1 && n < 40) begin
            if (n == clr_at) clear = 1;
            step();
            clear = 0;
            n++;
        end
        chk("sweep_len", n, exp_n);
    endtask

    task automatic chk_reset_vals();
        chk("rst_busy", busy, 1);
        chk("rst_ack", ack, 0);
        chk("rst_dbg_ack", dbg_ack, 0);
        chk("rst_err", err, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_dbg_rdata", dbg_rdata, 0);
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            exp_t e;
            while (q_main.size() > 0 && q_main[0].cyc < cyc) begin
                e = q_main.pop_front();
                chk("main_ack_missing", 0, 1);
            end
            while (q_dbg.size() > 0 && q_dbg[0].cyc < cyc) begin
                e = q_dbg.pop_front();
                chk("dbg_ack_missing", 0, 1);
            end
            if (ack) begin
                if (q_main.size() == 0) chk("main_ack_unexpected", 1, 0);
                else begin
                    e = q_main.pop_front();
                    chk("main_ack_cycle", cyc, e.cyc);
                    chk("main_rdata", rdata, e.rd);
                    chk("main_err", err, e.err);
                end
            end
            if (dbg_ack) begin
                if (q_dbg.size() == 0) chk("dbg_ack_unexpected", 1, 0);
                else begin
                    e = q_dbg.pop_front();
                    chk("dbg_ack_cycle", cyc, e.cyc);
                    chk("dbg_rdata", dbg_rdata, e.rd);
                    chk("dbg_err", err, e.err);
                end
            end
            if (err && !ack && !dbg_ack) chk("err_without_ack", 1, 0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1;
        idle();
        last_rd[0] = '0; last_rd[1] = '0;
        // Reset release with a read of addr 5 already pending.
        req = 1; addr = 8'd5;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals();
        reset = 0;
        model_zero();
        count_busy(-1, 16);
        exp_acc(0, 0, 5, '0);
        step();
        idle();
        step();

        // Write then immediate read of the same address.
        issue(0, 1, 3, 8'hA5); step();
        issue(0, 0, 3, 8'h00); step();
        idle(); step();

        // Same-cycle main and debug writes: debug first, main lands last.
        collide(1, 7, 8'h11, 1, 7, 8'h22);
        issue(1, 0, 7, 8'h00); step();
        idle(); step();

        // Out-of-range accesses; addr 4 must stay untouched.
        issue(0, 1, 4, 8'h3C); step();
        issue(0, 1, 20, 8'h55); step();
        issue(0, 0, 20, 8'h00); step();
        issue(0, 0, 4, 8'h00); step();
        issue(1, 0, 255, 8'h00); step();
        idle(); step();

        // Clear in the same cycle as a request: request is discarded.
        req = 1; we = 0; addr = 8'd3; clear = 1;
        model_zero();
        step();
        idle();
        count_busy(-1, 16);
        issue(0, 0, 3, 8'h00); step();
        idle(); step();

        // Clear while sweeping is ignored.
        clear = 1; step(); idle();
        count_busy(5, 16);

        // Randomized traffic over in- and out-of-range addresses.
        for (int i = 0; i < 300; i++) begin
            int k = $urandom_range(0, 9);
            int a = $urandom_range(0, 23);
            int a2 = $urandom_range(0, 23);
            bit w = 1'($urandom_range(0, 1));
            bit w2 = 1'($urandom_range(0, 1));
            logic [DW-1:0] d = DW'($urandom);
            logic [DW-1:0] d2 = DW'($urandom);
            if (k < 1) begin idle(); step(); end
            else if (k < 6) begin issue(0, w, a, d); step(); end
            else if (k < 9) begin issue(1, w, a, d); step(); end
            else collide(w, a, d, w2, a2, d2);
        end
        idle(); step();

        // Fill with 0xFF, clear, then reset 8 cycles into the sweep.
        for (int i = 0; i < DEPTH; i++) begin issue(0, 1, i, 8'hFF); step(); end
        issue(0, 0, 9, 8'h00); step();
        issue(1, 0, 2, 8'h00); step();
        idle(); step();
        clear = 1; step(); clear = 0;
        model_zero();
        repeat (8) step();
        reset = 1;
        #1;
        chk_reset_vals();
        last_rd[0] = '0; last_rd[1] = '0;
        step();
        reset = 0;
        count_busy(-1, 16);
        for (int i = 0; i < DEPTH; i++) begin issue(0, 0, i, 8'h00); step(); end
        issue(1, 0, 15, 8'h00); step();
        idle();
        step(); step();

        chk("main_queue_drained", q_main.size(), 0);
        chk("dbg_queue_drained", q_dbg.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
